conv_pool_mc: RTL
=================

CONV_POOL_MC -- requirements
Module: conv_pool_mc

Interface
- REQ-001 Parameter NUM_CH, 3, number of 3x3 kernel channels processed in parallel (1..8).
- REQ-002 Parameter ADDR_W, 16, width of the block address.
- REQ-003 Parameter NUM_BLKS, 65536, number of 4x4 blocks per run (1..2**ADDR_W).
- REQ-004 clk  in  1  single clock; all logic on rising edge.
- REQ-005 rst  in  1  synchronous, active-high reset.
- REQ-006 start  in  1  one-cycle pulse that begins a run; honoured only in IDLE.
- REQ-007 out_ready  in  1  downstream ready; low stalls the pipeline.
- REQ-008 pool_avg  in  1  0 = 2x2 max pool, 1 = 2x2 average pool.
- REQ-009 relu_en  in  1  1 = clamp each conv result to >=0 before pooling.
- REQ-010 shift  in  2  output right-shift select.
- REQ-011 image_4x4  in  128  pixel p[r][c] = bits [8*(4r+c)+7 : 8*(4r+c)], unsigned, valid the cycle after input_re.
- REQ-012 conv_kernel  in  72*NUM_CH  weight w[ch][i][j] = bits [72*ch+8*(3i+j)+7 : 72*ch+8*(3i+j)], signed two's complement.
- REQ-013 input_re  out  1  image read enable.
- REQ-014 input_addr  out  ADDR_W  block index being read.
- REQ-015 output_we  out  NUM_CH  per-channel write enable, all bits asserted together.
- REQ-016 output_addr  out  ADDR_W  block index of the current result.
- REQ-017 y  out  8*NUM_CH  channel ch result on bits [8ch+7:8ch].
- REQ-018 busy  out  1  high from the cycle after an accepted start until done.
- REQ-019 done  out  1  one-cycle pulse after the last write.

Function
- REQ-020 FSM states IDLE, RUN, DRAIN, DONE; IDLE->RUN on start; RUN->DRAIN after read NUM_BLKS-1 is issued; DRAIN->DONE when no valid data remains in the pipeline; DONE->IDLE unconditionally after one cycle.
- REQ-021 kernel, shift, pool_avg and relu_en are latched on the accepted start; changes during a run have no effect.
- REQ-022 start outside IDLE is ignored.
- REQ-023 In RUN, input_re is high each cycle that out_ready=1 and the capture register is empty or draining; input_addr counts 0..NUM_BLKS-1 with no gaps or repeats.
- REQ-024 A capture register samples image_4x4 exactly one cycle after every input_re, including during a stall; no block is lost or duplicated.
- REQ-025 While out_ready=0, all pipeline stages hold, input_re=0, and output_we=0.
- REQ-026 Conv output at position (a,b), a,b in {0,1}: S = sum over i,j of p[a+i][b+j]*w[i][j], computed as a 20-bit signed result with no overflow.
- REQ-027 If relu_en=1, each S<0 is replaced by 0 before pooling.
- REQ-028 Max pool takes the signed maximum of the four S values; avg pool takes the sum of the four S values, arithmetic right-shifted by 2 (floor).
- REQ-029 The pooled value is arithmetic right-shifted by 2*shift bits (0/2/4/6), then saturated to 0..255.
- REQ-030 With no stall, output_we rises exactly 4 cycles after the input_re of the same block; output_addr equals that block's input_addr; stalls add cycles one-for-one.
- REQ-031 Exactly NUM_BLKS write cycles occur per run; done pulses the cycle after the last write.

Reset
- REQ-032 While rst is high at a clock edge, the FSM goes to IDLE, all counters and valid bits clear, and input_re, input_addr, output_we, output_addr, y, busy and done are all 0 from the next cycle.
- REQ-033 rst mid-run aborts the run with no further writes; a subsequent start restarts from address 0.

Verification
- REQ-034 Scenario: rst held for 2 cycles -> every output is 0; start with out_ready low -> busy=1, input_re=0.
- REQ-035 Scenario: NUM_BLKS=4, all pixels 1, all weights 1, shift=0, max pool -> 4 writes, y=9 on every channel, addresses 0..3, each write exactly 4 cycles after its read, done once.
- REQ-036 Scenario: pixels 255, weights 127, shift=3 -> y=255 (saturated high); weights -128, relu_en=0 -> y=0 (saturated low).
- REQ-037 Scenario: only w[1][1]=1 (all other weights 0), p[1][1]=10, p[1][2]=20, p[2][1]=30, p[2][2]=41 -> max pool y=41, avg pool y=25; w[1][1]=-1, avg pool, shift=0 -> relu_en=0 gives y=0 (pre-saturation -26) and relu_en=1 gives y=0 with every S clamped.
- REQ-038 Scenario: NUM_BLKS=16, out_ready low for 3 cycles mid-run, with a read issued in the cycle before the stall -> 16 writes, addresses 0..15 each exactly once, results match the golden values, done after the 16th write.
- REQ-039 Scenario: rst asserted after block 5 is written, then start -> no writes occur during reset, and the new run writes from address 0 with the newly latched kernels.

Source files
------------

// File: rtl/conv_pool_mc.sv
// Multi-channel 3x3 convolution over a 4x4 pixel block, followed by ReLU, 2x2 max/avg pooling,
// a programmable right shift and 0..255 saturation. Streams NUM_BLKS blocks per run.
module conv_pool_mc #(
    parameter int unsigned NUM_CH   = 3,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned NUM_BLKS = 65536
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   out_ready,
    input  logic                   pool_avg,
    input  logic                   relu_en,
    input  logic [1:0]             shift,
    input  logic [127:0]           image_4x4,
    input  logic [72*NUM_CH-1:0]   conv_kernel,
    output logic                   input_re,
    output logic [ADDR_W-1:0]      input_addr,
    output logic [NUM_CH-1:0]      output_we,
    output logic [ADDR_W-1:0]      output_addr,
    output logic [8*NUM_CH-1:0]    y,
    output logic                   busy,
    output logic                   done
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_BLKS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e                 state_q, state_d;
    logic [72*NUM_CH-1:0]   kern_q, kern_d;
    logic [1:0]             shift_q, shift_d;
    logic                   avg_q, avg_d;
    logic                   relu_q, relu_d;
    logic [ADDR_W-1:0]      rd_addr_q, rd_addr_d;

    // Stage 0: read in flight; image arrives this cycle, or sits in the skid if we stalled.
    logic                   pend_vld_q, pend_vld_d;
    logic [ADDR_W-1:0]      pend_addr_q, pend_addr_d;
    logic                   skid_vld_q, skid_vld_d;
    logic [127:0]           skid_q, skid_d;
    // Stage 1: captured block.
    logic                   cap_vld_q, cap_vld_d;
    logic [127:0]           cap_q, cap_d;
    logic [ADDR_W-1:0]      cap_addr_q, cap_addr_d;
    // Stage 2: four conv results per channel.
    logic                   conv_vld_q, conv_vld_d;
    logic signed [19:0]     conv_q [NUM_CH][4];
    logic signed [19:0]     conv_d [NUM_CH][4];
    logic [ADDR_W-1:0]      conv_addr_q, conv_addr_d;
    // Stage 3: pooled, shifted and saturated result.
    logic                   out_vld_q, out_vld_d;
    logic [8*NUM_CH-1:0]    y_q, y_d;
    logic [ADDR_W-1:0]      out_addr_q, out_addr_d;

    function automatic logic signed [19:0] conv_at(input logic [127:0] img,
                                                   input logic [71:0] k,
                                                   input int unsigned a,
                                                   input int unsigned b);
        logic signed [19:0] acc;
        logic signed [8:0]  pix;
        logic signed [7:0]  wt;
        logic signed [16:0] prod;
        acc = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            for (int unsigned j = 0; j < 3; j++) begin
                pix  = {1'b0, img[8*(4*(a+i)+b+j) +: 8]};
                wt   = k[8*(3*i+j) +: 8];
                prod = 17'(pix) * 17'(wt);
                acc  = acc + 20'(prod);
            end
        end
        return acc;
    endfunction

    function automatic logic [7:0] pool_sat(input logic signed [19:0] s0,
                                            input logic signed [19:0] s1,
                                            input logic signed [19:0] s2,
                                            input logic signed [19:0] s3,
                                            input logic avg,
                                            input logic relu,
                                            input logic [1:0] sh);
        logic signed [19:0] v [4];
        logic signed [19:0] mx;
        logic signed [21:0] sum;
        logic signed [21:0] pooled;
        logic signed [21:0] res;
        logic [7:0]         r;
        v[0] = s0;
        v[1] = s1;
        v[2] = s2;
        v[3] = s3;
        for (int k = 0; k < 4; k++) begin
            if (relu && v[k][19]) begin
                v[k] = '0;
            end
        end
        mx = v[0];
        for (int k = 1; k < 4; k++) begin
            if (v[k] > mx) begin
                mx = v[k];
            end
        end
        sum    = 22'(v[0]) + 22'(v[1]) + 22'(v[2]) + 22'(v[3]);
        pooled = avg ? (sum >>> 2) : 22'(mx);
        res    = pooled >>> {sh, 1'b0};
        if (res[21]) begin
            r = 8'd0;
        end else if (res > 22'sd255) begin
            r = 8'hff;
        end else begin
            r = res[7:0];
        end
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        kern_d      = kern_q;
        shift_d     = shift_q;
        avg_d       = avg_q;
        relu_d      = relu_q;
        rd_addr_d   = rd_addr_q;
        pend_vld_d  = pend_vld_q;
        pend_addr_d = pend_addr_q;
        skid_vld_d  = skid_vld_q;
        skid_d      = skid_q;
        cap_vld_d   = cap_vld_q;
        cap_d       = cap_q;
        cap_addr_d  = cap_addr_q;
        conv_vld_d  = conv_vld_q;
        conv_d      = conv_q;
        conv_addr_d = conv_addr_q;
        out_vld_d   = out_vld_q;
        y_d         = y_q;
        out_addr_d  = out_addr_q;
        input_re    = (state_q == StRun) && out_ready;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StRun;
                    kern_d    = conv_kernel;
                    shift_d   = shift;
                    avg_d     = pool_avg;
                    relu_d    = relu_en;
                    rd_addr_d = '0;
                end
            end
            StRun: begin
                if (input_re) begin
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                    if (rd_addr_q == LastAddr) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // Leave once the final write is happening this cycle.
                if (!pend_vld_q && !cap_vld_q && !conv_vld_q && (!out_vld_q || out_ready)) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (out_ready) begin
            pend_vld_d  = input_re;
            pend_addr_d = rd_addr_q;
            skid_vld_d  = 1'b0;
            cap_vld_d   = pend_vld_q;
            if (pend_vld_q) begin
                cap_d      = skid_vld_q ? skid_q : image_4x4;
                cap_addr_d = pend_addr_q;
            end
            conv_vld_d = cap_vld_q;
            if (cap_vld_q) begin
                for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                    for (int unsigned pos = 0; pos < 4; pos++) begin
                        conv_d[ch][pos] = conv_at(cap_q, kern_q[72*ch +: 72], pos / 2, pos % 2);
                    end
                end
                conv_addr_d = cap_addr_q;
            end
            out_vld_d = conv_vld_q;
            if (conv_vld_q) begin
                for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                    y_d[8*ch +: 8] = pool_sat(conv_q[ch][0], conv_q[ch][1], conv_q[ch][2],
                                              conv_q[ch][3], avg_q, relu_q, shift_q);
                end
                out_addr_d = conv_addr_q;
            end
        end else if (pend_vld_q && !skid_vld_q) begin
            // Image is only valid this one cycle; hold it until the pipeline moves again.
            skid_d     = image_4x4;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            kern_q      <= '0;
            shift_q     <= '0;
            avg_q       <= 1'b0;
            relu_q      <= 1'b0;
            rd_addr_q   <= '0;
            pend_vld_q  <= 1'b0;
            pend_addr_q <= '0;
            skid_vld_q  <= 1'b0;
            skid_q      <= '0;
            cap_vld_q   <= 1'b0;
            cap_q       <= '0;
            cap_addr_q  <= '0;
            conv_vld_q  <= 1'b0;
            conv_q      <= '{default: '0};
            conv_addr_q <= '0;
            out_vld_q   <= 1'b0;
            y_q         <= '0;
            out_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            kern_q      <= kern_d;
            shift_q     <= shift_d;
            avg_q       <= avg_d;
            relu_q      <= relu_d;
            rd_addr_q   <= rd_addr_d;
            pend_vld_q  <= pend_vld_d;
            pend_addr_q <= pend_addr_d;
            skid_vld_q  <= skid_vld_d;
            skid_q      <= skid_d;
            cap_vld_q   <= cap_vld_d;
            cap_q       <= cap_d;
            cap_addr_q  <= cap_addr_d;
            conv_vld_q  <= conv_vld_d;
            conv_q      <= conv_d;
            conv_addr_q <= conv_addr_d;
            out_vld_q   <= out_vld_d;
            y_q         <= y_d;
            out_addr_q  <= out_addr_d;
        end
    end

    assign input_addr  = rd_addr_q;
    assign output_we   = {NUM_CH{out_vld_q & out_ready}};
    assign output_addr = out_addr_q;
    assign y           = y_q;
    assign busy        = (state_q == StRun) || (state_q == StDrain);
    assign done        = (state_q == StDone);

endmodule
